// File: rtl/secnotas.sv
`default_nettype none
// ============================================================================
// Module   : secnotas
// Brief    : Four-note square-wave sequencer with a synchronised button gate.
// Revision : 1.0 - initial release
// ============================================================================
module secnotas #(
    parameter int N0  = 45866,
    parameter int N1  = 40864,
    parameter int N2  = 36404,
    parameter int N3  = 34361,
    parameter int DUR = 6000000
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic ch_out
);

    localparam int c_NMAX01 = (N0 > N1) ? N0 : N1;
    localparam int c_NMAX23 = (N2 > N3) ? N2 : N3;
    localparam int c_NMAX   = (c_NMAX01 > c_NMAX23) ? c_NMAX01 : c_NMAX23;
    localparam int c_TW     = $clog2(c_NMAX);
    localparam int c_DW     = (DUR > 1) ? $clog2(DUR) : 1;

    localparam logic [c_DW-1:0] c_DLAST = c_DW'(DUR - 1);
    localparam logic [c_DW-1:0] c_DONE  = c_DW'(1);
    localparam logic [c_TW-1:0] c_TONE  = c_TW'(1);

    logic [1:0]      r_idx;
    logic [c_DW-1:0] r_dcnt;
    logic [c_TW-1:0] r_tcnt;
    logic            r_b1;
    logic            r_b2;
    logic            r_ch_out;

    logic [c_TW-1:0] w_nsel_m1;
    logic [c_TW-1:0] w_half;
    logic            w_dend;
    logic            w_twrap;
    logic            w_tone;

    // Per-note wrap point and high/low split of the tone period
    always_comb begin
        w_nsel_m1 = c_TW'(N0 - 1);
        w_half    = c_TW'(N0 / 2);
        case (r_idx)
            2'd0: begin
                w_nsel_m1 = c_TW'(N0 - 1);
                w_half    = c_TW'(N0 / 2);
            end
            2'd1: begin
                w_nsel_m1 = c_TW'(N1 - 1);
                w_half    = c_TW'(N1 / 2);
            end
            2'd2: begin
                w_nsel_m1 = c_TW'(N2 - 1);
                w_half    = c_TW'(N2 / 2);
            end
            default: begin
                w_nsel_m1 = c_TW'(N3 - 1);
                w_half    = c_TW'(N3 / 2);
            end
        endcase
    end

    assign w_dend  = (r_dcnt == c_DLAST);
    assign w_twrap = (r_tcnt == w_nsel_m1);
    assign w_tone  = (r_tcnt < w_half);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx    <= 2'd0;
            r_dcnt   <= '0;
            r_tcnt   <= '0;
            r_b1     <= 1'b0;
            r_b2     <= 1'b0;
            r_ch_out <= 1'b0;
        end else begin
            r_b1     <= button;
            r_b2     <= r_b1;
            r_ch_out <= r_b2 & w_tone;
            // A note change restarts the tone period, overriding its own wrap
            if (w_dend) begin
                r_dcnt <= '0;
                r_idx  <= r_idx + 2'd1;
                r_tcnt <= '0;
            end else begin
                r_dcnt <= r_dcnt + c_DONE;
                r_tcnt <= w_twrap ? '0 : (r_tcnt + c_TONE);
            end
        end
    end

    assign ch_out = r_ch_out;

endmodule
`default_nettype wire

// File: tb/tb_secnotas.sv
`default_nettype none
// ============================================================================
// Module   : tb_secnotas
// Brief    : Directed self-checking bench for secnotas (N=4,3,2,5, DUR=10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_secnotas;

    logic clk;
    logic rst;
    logic button;
    logic ch_out;

    int n_checks;
    int n_pass;

    // Tone level for cycles 0..39 after reset release, derived by hand
    logic [0:39] r_tone_tab;
    logic [0:79] r_btn_hist;

    secnotas #(
        .N0 (4),
        .N1 (3),
        .N2 (2),
        .N3 (5),
        .DUR(10)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .button(button),
        .ch_out(ch_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(input int n, input logic check_out);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (check_out) chk($sformatf("rst_ch[%0d]", i), 32'(ch_out), 32'd0);
        end
        rst = 1'b0;
    endtask

    // mode 0: button held 1, mode 1: toggles every 4 cycles, mode 2: held 0
    task automatic run(input string name, input int n, input int mode);
        logic exp_ch;
        logic b;
        for (int c = 0; c < n; c++) begin
            case (mode)
                0:       b = 1'b1;
                1:       b = ((c / 4) % 2) == 0;
                default: b = 1'b0;
            endcase
            button        = b;
            r_btn_hist[c] = b;
            tick();
            exp_ch = (c >= 2) ? (r_btn_hist[c-2] & r_tone_tab[c % 40]) : 1'b0;
            chk($sformatf("%s_ch[%0d]", name, c), 32'(ch_out), 32'(exp_ch));
            chk($sformatf("%s_idx[%0d]", name, c), 32'(dut.r_idx), 32'(((c + 1) / 10) % 4));
        end
    endtask

    initial begin
        clk      = 1'b0;
        rst      = 1'b1;
        button   = 1'b1;
        n_checks = 0;
        n_pass   = 0;
        r_btn_hist = '0;
        r_tone_tab = {10'b1100110011,
                      10'b1001001001,
                      10'b1010101010,
                      10'b1100011000};

        // Reset held 3 cycles with button high
        pulse_reset(3, 1'b1);
        chk("rst_idx",  32'(dut.r_idx),  32'd0);
        chk("rst_dcnt", 32'(dut.r_dcnt), 32'd0);
        chk("rst_tcnt", 32'(dut.r_tcnt), 32'd0);

        // Full note sequence and wrap back to note 0
        run("seq", 50, 0);

        // Button gating
        pulse_reset(2, 1'b0);
        run("gate", 40, 1);

        // Reset in the middle of note 2 (dcnt = 5)
        pulse_reset(1, 1'b0);
        button = 1'b1;
        repeat (25) tick();
        chk("mid_pre_idx",  32'(dut.r_idx),  32'd2);
        chk("mid_pre_dcnt", 32'(dut.r_dcnt), 32'd5);
        pulse_reset(1, 1'b1);
        chk("mid_idx",  32'(dut.r_idx),  32'd0);
        chk("mid_dcnt", 32'(dut.r_dcnt), 32'd0);
        chk("mid_tcnt", 32'(dut.r_tcnt), 32'd0);
        run("mid", 12, 0);

        // Button low: silent output while notes keep advancing
        pulse_reset(1, 1'b0);
        run("low", 50, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
